// File: rtl/multicycle_pkg.sv
// Shared definitions for the multicycle processor control FSM: opcodes,
// state encodings, datapath select codes and the decoded control word.
package multicycle_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_FETCH_IR = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMRD    = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWR    = 4'd6,
    S_RTYPE_EX = 4'd7,
    S_RTYPE_WB = 4'd8,
    S_BEQ      = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_JUMP     = 4'd12,
    S_ILLEGAL  = 4'd13
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [2:0] SRCB_REG    = 3'b000;
  localparam logic [2:0] SRCB_FOUR   = 3'b001;
  localparam logic [2:0] SRCB_IMM    = 3'b010;
  localparam logic [2:0] SRCB_IMM_SH = 3'b011;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic [2:0] alu_src_b;
  } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// Moore output decode: maps the registered FSM state to the datapath control word.
module mc_output_decode
  import multicycle_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    // NOTE: the all-zero default covers every unlisted signal and keeps this block latch-free.
    ctrl = '0;
    case (state)
      S_FETCH: ctrl.mem_read = 1'b1;
      S_FETCH_IR: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PC_ALU;
        ctrl.pc_write  = 1'b1;
      end
      S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH;
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.i_or_d    = 1'b1;
      end
      S_MEMRD: begin
        ctrl.mem_read  = 1'b1;
        ctrl.i_or_d    = 1'b1;
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_IMM;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_RTYPE_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_RTYPE_WB: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_BRANCH;
      end
      S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_ADDI_WB: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.reg_write = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_JUMP;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle processor control unit: state register, opcode-driven next-state
// logic and a sticky illegal-opcode flag; outputs come from mc_output_decode.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opCode,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               IRWrite,
  output logic               ALUSrcA,
  output logic               RegWrite,
  output logic               RegDst,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUOp,
  output logic [2:0]         ALUSrcB,
  output logic [STATE_W-1:0] state,
  output logic               illegal
);

  state_t cur_state;
  ctrl_t  ctrl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state <= S_FETCH;
      illegal   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      case (cur_state)
        S_FETCH:    cur_state <= S_FETCH_IR;
        S_FETCH_IR: cur_state <= S_DECODE;
        S_DECODE: begin
          case (opCode)
            OP_RTYPE:     cur_state <= S_RTYPE_EX;
            OP_LW, OP_SW: cur_state <= S_MEMADR;
            OP_BEQ:       cur_state <= S_BEQ;
            OP_ADDI:      cur_state <= S_ADDI_EX;
            OP_J:         cur_state <= S_JUMP;
            default: begin
              cur_state <= S_ILLEGAL;
              illegal   <= 1'b1;
            end
          endcase
        end
        // The opcode is re-examined here; anything other than lw/sw is treated as illegal.
        S_MEMADR: begin
          if (opCode == OP_LW) begin
            cur_state <= S_MEMRD;
          end else if (opCode == OP_SW) begin
            cur_state <= S_MEMWR;
          end else begin
            cur_state <= S_ILLEGAL;
            illegal   <= 1'b1;
          end
        end
        S_MEMRD:    cur_state <= S_MEMWB;
        S_RTYPE_EX: cur_state <= S_RTYPE_WB;
        S_ADDI_EX:  cur_state <= S_ADDI_WB;
        S_ILLEGAL:  cur_state <= S_ILLEGAL;
        default:    cur_state <= S_FETCH;
      endcase
    end
  end

  mc_output_decode u_decode (
    .state (cur_state),
    .ctrl  (ctrl)
  );

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.i_or_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign IRWrite     = ctrl.ir_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign RegWrite    = ctrl.reg_write;
  assign RegDst      = ctrl.reg_dst;
  assign PCSource    = ctrl.pc_source;
  assign ALUOp       = ctrl.alu_op;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign state       = STATE_W'(cur_state);

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver pushes the expected
// per-cycle state/control trace of each instruction, a negedge monitor compares.
module tb_multicycle_control;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         BQ = 6'b000100, AI = 6'b001000, JP = 6'b000010,
                         BAD = 6'b111111;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opCode;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst;
  logic [1:0] PCSource, ALUOp;
  logic [2:0] ALUSrcB;
  logic [3:0] state;
  logic       illegal;

  multicycle_control #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .opCode(opCode),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .PCSource(PCSource), .ALUOp(ALUOp),
    .ALUSrcB(ALUSrcB), .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          st;
    logic [18:0] ctrl;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   plan[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [18:0] actual_ctrl();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
            ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB};
  endfunction

  // Control word expected in each state, written straight from the state table.
  function automatic logic [18:0] exp_ctrl(input int s);
    logic pw = 0, pwc = 0, iod = 0, mr = 0, mw = 0, m2r = 0, irw = 0, sa = 0, rw = 0, rd = 0;
    logic [1:0] pcs = 2'b00, aop = 2'b00;
    logic [2:0] sb_sel = 3'b000;
    case (s)
      0:  mr = 1;
      1:  begin mr = 1; irw = 1; sb_sel = 3'b001; pw = 1; end
      2:  sb_sel = 3'b011;
      3:  begin sa = 1; sb_sel = 3'b010; iod = 1; end
      4:  begin mr = 1; iod = 1; sa = 1; sb_sel = 3'b010; end
      5:  begin rw = 1; m2r = 1; sa = 1; sb_sel = 3'b010; end
      6:  begin mw = 1; iod = 1; sa = 1; sb_sel = 3'b010; end
      7:  begin sa = 1; aop = 2'b10; end
      8:  begin sa = 1; aop = 2'b10; rw = 1; rd = 1; end
      9:  begin sa = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; end
      10: begin sa = 1; sb_sel = 3'b010; end
      11: begin sa = 1; sb_sel = 3'b010; rw = 1; end
      12: begin pw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {pw, pwc, iod, mr, mw, m2r, irw, sa, rw, rd, pcs, aop, sb_sel};
  endfunction

  // Reference model: common fetch/decode prefix plus the per-opcode tail.
  task automatic build_plan(input logic [5:0] op);
    plan = '{0, 1, 2};
    case (op)
      LW: plan = {plan, 3, 4, 5};
      SW: plan = {plan, 3, 6};
      RT: plan = {plan, 7, 8};
      BQ: plan = {plan, 9};
      AI: plan = {plan, 10, 11};
      JP: plan = {plan, 12};
      default: ;
    endcase
  endtask

  // Drive the first n cycles of an instruction (n < 0 means all of it).
  task automatic run_instr(input logic [5:0] op, input int n);
    exp_t e;
    build_plan(op);
    if (n < 0) n = plan.size();
    for (int i = 0; i < n; i++) begin
      opCode  = (plan[i] == 2 || plan[i] == 3) ? op : 6'($urandom);
      e.st    = plan[i];
      e.ctrl  = exp_ctrl(plan[i]);
      e.ill   = 1'b0;
      sb.push_back(e);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    check("scoreboard_drain", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      check("mw_rw_excl", {31'd0, MemWrite & RegWrite}, 0);
      check("pcw_pcwc_excl", {31'd0, PCWrite & PCWriteCond}, 0);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("state", {28'd0, state}, e.st);
        check("ctrl", {13'd0, actual_ctrl()}, {13'd0, e.ctrl});
        check("illegal_flag", {31'd0, illegal}, {31'd0, e.ill});
      end
    end
  end

  task automatic reset_checks(input string tag);
    check({tag, "_state"}, {28'd0, state}, 0);
    check({tag, "_illegal"}, {31'd0, illegal}, 0);
    check({tag, "_ctrl"}, {13'd0, actual_ctrl()}, {13'd0, exp_ctrl(0)});
  endtask

  initial begin
    logic [5:0] ops [6];
    exp_t       e;
    ops = '{LW, SW, RT, BQ, AI, JP};
    reset  = 1'b0;
    opCode = 6'd0;
    #2;
    reset_checks("por");
    repeat (3) @(posedge clk);
    #1;
    reset_checks("held_reset");
    reset = 1'b1;

    // Directed sequences, then randomized instruction mix.
    run_instr(LW, -1);
    run_instr(SW, -1);
    run_instr(RT, -1);
    run_instr(BQ, -1);
    run_instr(JP, -1);
    run_instr(AI, -1);
    for (int k = 0; k < 40; k++) run_instr(ops[$urandom_range(0, 5)], -1);
    drain();

    // Abort a store in MEMWR with an asynchronous reset away from any clock edge.
    run_instr(SW, 4);
    drain();
    check("abort_in_memwr", {28'd0, state}, 6);
    check("abort_memwrite_hi", {31'd0, MemWrite}, 1);
    check("abort_iord_hi", {31'd0, IorD}, 1);
    #2 reset = 1'b0;
    #1;
    check("abort_memwrite_lo", {31'd0, MemWrite}, 0);
    check("abort_mw_rw_excl", {31'd0, MemWrite & RegWrite}, 0);
    reset_checks("abort");
    repeat (2) @(posedge clk);
    #1;
    reset_checks("abort_held");
    reset = 1'b1;

    // Illegal opcode locks the FSM until reset.
    run_instr(BAD, 3);
    for (int k = 0; k < 20; k++) begin
      opCode = 6'($urandom);
      e.st   = 13;
      e.ctrl = '0;
      e.ill  = 1'b1;
      sb.push_back(e);
      @(posedge clk);
      #1;
    end
    drain();
    #2 reset = 1'b0;
    #1;
    reset_checks("illegal_clear");
    @(posedge clk);
    #1;
    reset = 1'b1;

    run_instr(LW, -1);
    run_instr(JP, -1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter: STATE_W, 4, width of the state register and of the state debug output.
REQ-003 clk  input  1  rising-edge clock shared with the datapath.
REQ-004 reset  input  1  asynchronous, active-low; 0 forces FETCH immediately.
REQ-005 opCode  input  6  instruction opcode from the instruction register.
REQ-006 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  output  1 each  datapath strobes and selects.
REQ-007 PCSource  output  2  next-PC select: 00 = ALU (PC+4), 01 = ALU (branch), 10 = jump target.
REQ-008 ALUOp  output  2  ALU operation: 00 = add, 01 = subtract, 10 = funct-decoded.
REQ-009 ALUSrcB  output  3  ALU B select: 000 = B, 001 = constant 4, 010 = sign-extended immediate, 011 = shifted immediate; bit 2 SHALL always be 0.
REQ-010 state  output  STATE_W  current state, for debug.
REQ-011 illegal  output  1  sticky flag set when an unsupported opcode is decoded.

Function
REQ-012 The block SHALL be a Moore FSM; every output is decoded only from the registered state.
REQ-013 Any output not listed for a state SHALL be 0.
REQ-014 States and encodings: FETCH = 0, FETCH_IR = 1, DECODE = 2, MEMADR = 3, MEMRD = 4, MEMWB = 5, MEMWR = 6, RTYPE_EX = 7, RTYPE_WB = 8, BEQ = 9, ADDI_EX = 10, ADDI_WB = 11, JUMP = 12, ILLEGAL = 13; codes 14 and 15 SHALL transition to FETCH.
REQ-015 FETCH: MemRead = 1, IorD = 0; next state FETCH_IR. This state covers the one-cycle synchronous RAM read latency.
REQ-016 FETCH_IR: MemRead = 1, IRWrite = 1, ALUSrcA = 0, ALUSrcB = 001, ALUOp = 00, PCSource = 00, PCWrite = 1; next state DECODE.
REQ-017 DECODE: ALUSrcA = 0, ALUSrcB = 011, ALUOp = 00. Next state by opCode: 000000 goes to RTYPE_EX; 100011 (lw) and 101011 (sw) go to MEMADR; 000100 goes to BEQ; 001000 goes to ADDI_EX; 000010 goes to JUMP; any other value goes to ILLEGAL.
REQ-018 MEMADR: ALUSrcA = 1, ALUSrcB = 010, ALUOp = 00, IorD = 1. Next state is MEMRD for lw and MEMWR for sw.
REQ-019 MEMRD: MemRead = 1, IorD = 1, ALUSrcA = 1, ALUSrcB = 010; next state MEMWB.
REQ-020 MEMWB: RegWrite = 1, MemtoReg = 1, RegDst = 0, ALUSrcA = 1, ALUSrcB = 010; next state FETCH.
REQ-021 MEMWR: MemWrite = 1, IorD = 1, ALUSrcA = 1, ALUSrcB = 010; next state FETCH.
REQ-022 RTYPE_EX: ALUSrcA = 1, ALUSrcB = 000, ALUOp = 10; next state RTYPE_WB.
REQ-023 RTYPE_WB: the RTYPE_EX selects plus RegWrite = 1, RegDst = 1, MemtoReg = 0; next state FETCH.
REQ-024 BEQ: ALUSrcA = 1, ALUSrcB = 000, ALUOp = 01, PCWriteCond = 1, PCSource = 01; next state FETCH.
REQ-025 ADDI_EX: ALUSrcA = 1, ALUSrcB = 010, ALUOp = 00; next state ADDI_WB.
REQ-026 ADDI_WB: the ADDI_EX selects plus RegWrite = 1, RegDst = 0; next state FETCH.
REQ-027 JUMP: PCWrite = 1, PCSource = 10; next state FETCH.
REQ-028 ILLEGAL: all strobes are 0; the state is held until reset.
REQ-029 Instruction latency SHALL be: lw 6 cycles; sw, R-type and addi 5 cycles; beq and j 4 cycles.
REQ-030 opCode SHALL be sampled only in DECODE and MEMADR; changes on opCode in other states SHALL be ignored.
REQ-031 MemWrite and RegWrite SHALL never both be 1 in the same cycle.
REQ-032 PCWrite and PCWriteCond SHALL never both be 1 in the same cycle.

Reset
REQ-033 While reset = 0, state SHALL be FETCH and illegal SHALL be 0; the outputs then equal the FETCH decode (MemRead = 1, all others 0).
REQ-034 Reset asserted in any state, including mid-instruction, SHALL abort the instruction with no further write strobes.
REQ-035 After reset release, the first rising edge SHALL move the FSM from FETCH to FETCH_IR.

Structure
REQ-036 The shared package multicycle_pkg SHALL hold the opcode constants, the state encodings, and the ALUOp, ALUSrcB and PCSource codes.
REQ-037 The output decode is a natural sub-module, mc_output_decode (state in, control word out). The state register and next-state logic stay in multicycle_control.

Verification
REQ-038 lw sequence: reset, opCode = 100011 → states 0,1,2,3,4,5,0; MemtoReg = 1 and RegWrite = 1 only in state 5.
REQ-039 sw sequence: opCode = 101011 → states 0,1,2,3,6,0; MemWrite = 1 only in state 6, with IorD = 1.
REQ-040 R-type then beq: opCode = 000000, then 000100 → R-type asserts RegDst = 1 and ALUOp = 10 in state 8; the beq cycle shows PCWriteCond = 1, ALUOp = 01 and PCSource = 01 in state 9.
REQ-041 jump: opCode = 000010 → 4 cycles total; PCWrite = 1 with PCSource = 10 in state 12.
REQ-042 illegal opcode: opCode = 111111 in DECODE → state 13 and illegal = 1 held for 20 cycles; reset = 0 clears both.
REQ-043 reset mid-instruction: reset = 0 asserted asynchronously in MEMWR → MemWrite falls without waiting for a clock edge and state = 0; all properties in REQ-031/REQ-032 hold throughout.
